// File: rtl/mole_pkg.sv
// Shared types and default constants for the whack-a-mole scheduler.
package mole_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SHOW = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam int          NUM_HOLES       = 8;
  localparam int          DEF_SHOW_FRAMES = 60;
  localparam int          DEF_GAP_FRAMES  = 30;
  localparam int          DEF_MAX_MISS    = 8;
  localparam logic [15:0] DEF_LFSR_SEED   = 16'hACE1;

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11; SEED must be nonzero.
module mole_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= SEED;
    else if (en)
      state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
  end

endmodule

// File: rtl/mole_scheduler.sv
// Mole game sequencer: picks a hole, times the show/gap windows, counts hits and misses.
// Optional macro MOLE_SPEEDUP_EN shortens the show window after every 8th hit.
//
// state   | meaning
// IDLE    | waiting for first start, no mole
// GAP     | dark interval, counting down GAP_FRAMES
// SHOW    | mole lit on led, counting down the show window
// OVER    | miss limit reached, waiting for start
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int          SHOW_FRAMES = DEF_SHOW_FRAMES,
  parameter int          GAP_FRAMES  = DEF_GAP_FRAMES,
  parameter int          MAX_MISS    = DEF_MAX_MISS,
  parameter logic [15:0] LFSR_SEED   = DEF_LFSR_SEED
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] key,
  output logic [NUM_HOLES-1:0] led,
  output logic [7:0]           score,
  output logic [3:0]           miss,
  output logic                 game_over
);

  localparam logic [7:0] GAP_LEN  = 8'(GAP_FRAMES);
  localparam logic [7:0] SHOW_LEN = 8'(SHOW_FRAMES);
  localparam logic [3:0] MISS_END = 4'(MAX_MISS);

  state_t                state;
  logic [7:0]            cnt;
  logic [NUM_HOLES-1:0]  key_d;
  logic [NUM_HOLES-1:0]  key_rise;
  logic [15:0]           lfsr;
  logic [2:0]            prev_pos;
  logic [2:0]            new_pos;
  logic [3:0]            miss_inc;
  logic [7:0]            show_len;
  logic                  expiry;
  logic                  hit;
  logic                  wrong;

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .state (lfsr)
  );

  // led is one-hot on the mole hole during SHOW, so it doubles as the hit mask
  assign key_rise = key & ~key_d;
  assign hit      = (state == ST_SHOW) && |(key_rise & led);
  assign wrong    = (state == ST_SHOW) && |(key_rise & ~led);
  assign expiry   = frame_tick && (cnt == 8'd1);
  assign new_pos  = (lfsr[2:0] == prev_pos) ? lfsr[2:0] + 3'd1 : lfsr[2:0];
  assign miss_inc = miss + 4'd1;

`ifdef MOLE_SPEEDUP_EN
  logic [7:0] show_win;
  logic [7:0] win_next;
  logic [2:0] hit_cnt;

  assign show_len = show_win;

  always_comb begin
    win_next = show_win - (show_win >> 2);
    if (win_next < 8'd8)
      win_next = 8'd8;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      show_win <= SHOW_LEN;
      hit_cnt  <= 3'd0;
    end else if (start) begin
      show_win <= SHOW_LEN;
      hit_cnt  <= 3'd0;
    end else if (hit) begin
      hit_cnt <= hit_cnt + 3'd1;
      if (hit_cnt == 3'd7)
        show_win <= win_next;
    end
  end
`else
  assign show_len = SHOW_LEN;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 8'd0;
      key_d     <= '0;
      prev_pos  <= 3'd0;
      led       <= '0;
      score     <= 8'd0;
      miss      <= 4'd0;
      game_over <= 1'b0;
    end else begin
      key_d <= key;
      if (frame_tick && cnt != 8'd0)
        cnt <= cnt - 8'd1;

      // start restarts the game from any state
      if (start) begin
        state     <= ST_GAP;
        cnt       <= GAP_LEN;
        led       <= '0;
        score     <= 8'd0;
        miss      <= 4'd0;
        game_over <= 1'b0;
      end else begin
        case (state)
          ST_GAP: begin
            if (expiry) begin
              prev_pos <= new_pos;
              led      <= 8'b1 << new_pos;
              cnt      <= show_len;
              state    <= ST_SHOW;
            end
          end
          ST_SHOW: begin
            if (hit) begin
              if (score != 8'hFF)
                score <= score + 8'd1;
              led   <= '0;
              cnt   <= GAP_LEN;
              state <= ST_GAP;
            end else if (wrong || expiry) begin
              miss <= miss_inc;
              if (miss_inc == MISS_END) begin
                led       <= '0;
                game_over <= 1'b1;
                state     <= ST_OVER;
              end else if (expiry) begin
                led   <= '0;
                cnt   <= GAP_LEN;
                state <= ST_GAP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 Parameter SHOW_FRAMES, default 60: frames a mole stays lit before timeout.
REQ-002 Parameter GAP_FRAMES, default 30: dark frames between moles.
REQ-003 Parameter MAX_MISS, default 8: miss count that ends the game.
REQ-004 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-005 clk  input  1  system clock; one clock for the whole block.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 frame_tick  input  1  one-cycle pulse per display frame (vertical-sync falling edge).
REQ-008 start  input  1  one-cycle start/restart request.
REQ-009 key  input  8  debounced hit buttons, active-high level, bit i = hole i.
REQ-010 led  output  8  one-hot hole select to the VGA driver; 8'h00 = no mole.
REQ-011 score  output  8  hit count, saturating.
REQ-012 miss  output  4  miss count.
REQ-013 game_over  output  1  high while in OVER.

Function
REQ-014 FSM states IDLE, GAP, SHOW, OVER; all outputs registered, with a 1-cycle update after the deciding edge.
REQ-015 IDLE: led=0; start -> GAP, frame counter loaded with GAP_FRAMES, score=0, miss=0.
REQ-016 Frame counter (8 bit) decrements only on frame_tick; expiry = frame_tick while counter==1.
REQ-017 GAP expiry: pos = LFSR[2:0]; if pos equals the previous pos, use pos+1 mod 8; led=1<<pos; -> SHOW, counter=SHOW_FRAMES.
REQ-018 Key rising edge = key & ~key_d, where key_d is key registered one cycle.
REQ-019 SHOW, rising edge on key[pos]: score+1 (saturate at 255); led=0; -> GAP, counter=GAP_FRAMES.
REQ-020 SHOW, rising edge only on other bits: miss+1; stay in SHOW; led unchanged.
REQ-021 SHOW expiry without a hit: miss+1; led=0; -> GAP.
REQ-022 Simultaneous events: a correct hit overrides a wrong key and an expiry in the same cycle (no miss).
REQ-023 Wrong key and expiry in the same cycle count as a single miss.
REQ-024 When miss reaches MAX_MISS: -> OVER, led=0, game_over=1; score and miss hold.
REQ-025 OVER: start -> same action as REQ-015; all other inputs are ignored.
REQ-026 start in GAP or SHOW restarts: score=0, miss=0, led=0, -> GAP.
REQ-027 Key edges in IDLE, GAP and OVER have no effect.
REQ-028 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every clk cycle.

Reset
REQ-029 rst_n low: state=IDLE, led=0, score=0, miss=0, game_over=0, counter=0, key_d=0, LFSR=LFSR_SEED, previous pos=0.
REQ-030 Reset mid-SHOW clears led on assertion, without waiting for a clock edge.

Configuration
REQ-031 Macro MOLE_SPEEDUP_EN defined: after each 8th hit, the show window becomes window - window/4, floored at 8 frames, and is applied from the next SHOW.
REQ-032 MOLE_SPEEDUP_EN undefined: the show window is fixed at SHOW_FRAMES; no speedup logic is present.

Structure
REQ-033 Package mole_pkg holds the state enum, the default parameter constants, and NUM_HOLES=8.
REQ-034 Sub-module mole_lfsr (seed parameter, enable, 16-bit state out) holds the LFSR.

Verification
REQ-035 Reset, then start, then 30 frame_ticks -> led becomes one-hot and matches the LFSR-derived pos.
REQ-036 With led=8'h04, pulse key[2] -> score 0->1, led=0 next cycle, GAP lasts 30 ticks.
REQ-037 With led=8'h04, pulse key[5] -> miss 0->1, led stays 8'h04; then 60 ticks -> miss=2, led=0.
REQ-038 key[pos] edge and the final expiry tick in the same cycle -> score+1, miss unchanged.
REQ-039 8 consecutive timeouts -> game_over=1, led=0; start -> score=0, miss=0, GAP.
REQ-040 With MOLE_SPEEDUP_EN, 8 hits -> the next SHOW times out after 45 ticks; the floor of 8 is reached and held.
